jzjpcc_fetch_stage: RTL

Fetch stage and IF/ID pipeline register of the jzjpcc pipelined RV32I core. Holds the fetch PC and drives the instruction memory address. Captures the fetched word into the IF/ID register and resolves JAL/JALR/BRANCH redirects in decode, using immediates from the immediate former plus rs1 and branch-compare results. Feeds `instruction_decode[31:2]` and decode-stage PCs to the rest of decode.

---
 rtl/jzjpcc_pkg.sv | 32 +++
 rtl/jzjpcc_nextPCLogic.sv | 48 ++++
 rtl/jzjpcc_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc RV32I core.
package jzjpcc_pkg;

  // Major opcode field, instruction bits [6:2]
  typedef enum logic [4:0] {
    OPCODE_LOAD     = 5'b00000,
    OPCODE_MISC_MEM = 5'b00011,
    OPCODE_OP_IMM   = 5'b00100,
    OPCODE_AUIPC    = 5'b00101,
    OPCODE_STORE    = 5'b01000,
    OPCODE_OP       = 5'b01100,
    OPCODE_LUI      = 5'b01101,
    OPCODE_BRANCH   = 5'b11000,
    OPCODE_JALR     = 5'b11001,
    OPCODE_JAL      = 5'b11011,
    OPCODE_SYSTEM   = 5'b11100
  } opcode_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // A control-transfer target must be 4-byte aligned (no compressed ISA)
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/jzjpcc_nextPCLogic.sv
// Decode-stage redirect resolution for JAL / JALR / taken BRANCH.
module jzjpcc_nextPCLogic
  import jzjpcc_pkg::*;
(
  input  opcode_t     opcode_i,
  input  logic        valid_i,
  input  logic [31:0] immediate_i_i,
  input  logic [31:0] immediate_b_i,
  input  logic [31:0] immediate_j_i,
  input  logic [31:0] rs1_value_i,
  input  logic        branch_taken_i,
  input  logic [31:0] pc_decode_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  logic transfer_s;

  // Select the transfer target and decide whether a transfer is requested
  always_comb begin
    transfer_s = 1'b0;
    target_o   = 32'h00000000;
    case (opcode_i)
      OPCODE_JAL: begin
        transfer_s = valid_i;
        target_o   = pc_decode_i + immediate_j_i;
      end
      OPCODE_JALR: begin
        transfer_s = valid_i;
        target_o   = (rs1_value_i + immediate_i_i) & ~32'h00000001;
      end
      OPCODE_BRANCH: begin
        transfer_s = valid_i & branch_taken_i;
        target_o   = pc_decode_i + immediate_b_i;
      end
      default: begin
        transfer_s = 1'b0;
        target_o   = 32'h00000000;
      end
    endcase
  end

  // A misaligned target turns the transfer into a fault instead of a redirect
  assign redirect_o   = transfer_s & ~is_misaligned(target_o);
  assign misaligned_o = transfer_s &  is_misaligned(target_o);

endmodule

// File: rtl/jzjpcc_fetch_stage.sv
// Fetch PC, IF/ID pipeline register and fetch fault FSM of the jzjpcc core.
module jzjpcc_fetch_stage
  import jzjpcc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        clock,
  input  logic        n_reset,
  output logic [31:0] pc_fetch,
  input  logic [31:0] instruction_fetch,
  input  logic        stall,
  input  logic [31:0] immediateI,
  input  logic [31:0] immediateB,
  input  logic [31:0] immediateJ,
  input  logic [31:0] rs1Value_decode,
  input  logic        branchTaken_decode,
  output logic [29:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic [31:0] pcPlus4_decode,
  output logic        decodeValid,
  output logic        fetchFault
);

  localparam logic [29:0] BUBBLE_BITS = NOP_INSTRUCTION[31:2];

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [29:0]  instr_q;
  logic [31:0]  pc_dec_q;
  logic [31:0]  pc4_dec_q;
  logic         valid_q;
  logic         fault_q;

  logic         redirect_s;
  logic [31:0]  target_s;
  logic         misaligned_s;
  logic         illegal_low_s;

  jzjpcc_nextPCLogic u_next_pc (
    .opcode_i       (opcode_t'(instr_q[4:0])),
    .valid_i        (valid_q),
    .immediate_i_i  (immediateI),
    .immediate_b_i  (immediateB),
    .immediate_j_i  (immediateJ),
    .rs1_value_i    (rs1Value_decode),
    .branch_taken_i (branchTaken_decode),
    .pc_decode_i    (pc_dec_q),
    .redirect_o     (redirect_s),
    .target_o       (target_s),
    .misaligned_o   (misaligned_s)
  );

  // Only 32-bit encodings (low bits 2'b11) are supported
  assign illegal_low_s = (instruction_fetch[1:0] != 2'b11);

  // PC, IF/ID register and RUN/HALTED state; stall has top priority in RUN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      instr_q   <= BUBBLE_BITS;
      pc_dec_q  <= 32'h00000000;
      pc4_dec_q <= 32'h00000004;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall) begin
            // Hold everything; a pending redirect waits for fresh rs1
            pc_q <= pc_q;
          end else if (redirect_s) begin
            pc_q    <= target_s;
            instr_q <= BUBBLE_BITS;
            valid_q <= 1'b0;
          end else if (misaligned_s || illegal_low_s) begin
            state_q <= HALTED;
            fault_q <= 1'b1;
            instr_q <= BUBBLE_BITS;
            valid_q <= 1'b0;
          end else begin
            instr_q   <= instruction_fetch[31:2];
            pc_dec_q  <= pc_q;
            pc4_dec_q <= pc_q + 32'd4;
            valid_q   <= 1'b1;
            pc_q      <= pc_q + 32'd4;
          end
        end
        HALTED: begin
          instr_q <= BUBBLE_BITS;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= HALTED;
          fault_q <= 1'b1;
          instr_q <= BUBBLE_BITS;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_fetch           = pc_q;
  assign instruction_decode = instr_q;
  assign pc_decode          = pc_dec_q;
  assign pcPlus4_decode     = pc4_dec_q;
  assign decodeValid        = valid_q;
  assign fetchFault         = fault_q;

endmodule
